// File: rtl/down_counter_pkg.sv
// Shared encodings for the loadable down counter: FSM states and run modes.
package down_counter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/down_counter_core.sv
// Count register with load / decrement / reload mux and the q==1 detect
// that marks the expiry edge.
module down_counter_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  input  logic             reload,
  input  logic [WIDTH-1:0] reload_val,
  output logic [WIDTH-1:0] q,
  output logic             is_one
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  assign is_one = (q_q == WIDTH'(1));
  assign q      = q_q;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (dec) begin
      // Expiry lands on the final value directly: 0 for one-shot, start value for reload.
      if (is_one) begin
        q_d = reload ? reload_val : '0;
      end else begin
        q_d = q_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/down_counter.sv
// Loadable down counter / cycle timer with one-shot and auto-reload modes.
// Holds the IDLE/RUN FSM, the reload value, the latched mode and the tc pulse.
module down_counter
  import down_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             tc_q, tc_d;

  logic             dec;
  logic             is_one;
  logic             expire;

  assign dec    = (state_q == ST_RUN) && en && !load;
  assign expire = dec && is_one;

  down_counter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_val   (load_val),
    .dec        (dec),
    .reload     (mode_q == MODE_RELOAD),
    .reload_val (reload_q),
    .q          (q),
    .is_one     (is_one)
  );

  always_comb begin
    state_d  = state_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    tc_d     = 1'b0;
    if (load) begin
      reload_d = load_val;
      mode_d   = mode;
      // A zero-length count expires on the load edge itself.
      if (load_val == '0) begin
        state_d = ST_IDLE;
        tc_d    = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else if (expire) begin
      tc_d = 1'b1;
      if (mode_q == MODE_ONESHOT) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      reload_q <= '0;
      mode_q   <= MODE_ONESHOT;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      tc_q     <= tc_d;
    end
  end

  assign tc   = tc_q;
  assign busy = (state_q == ST_RUN);

endmodule

// File: doc/down_counter.md
Name: down_counter

Overview:
- Loadable, parameterised down counter; the counting-down counterpart of the team's 4-bit ripple up counter.
- Used as a cycle timer: it is loaded with a start value, counts down on enabled cycles and flags terminal count.
- Supports one-shot and auto-reload operation.
- Fully synchronous datapath on a single clock.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..16.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable; one decrement per cycle while high and RUN.
- load  input  1  parallel load strobe; has priority over en.
- load_val  input  WIDTH  start and reload value, sampled when load=1.
- mode  input  1  0 = one-shot, 1 = auto-reload; sampled when load=1.
- q  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered, exactly one cycle wide.
- busy  output  1  high while state = RUN.

Behaviour:
- Reset (rst=1, asynchronous, any time including mid-count):
  - q=0, tc=0, busy=0.
  - State = IDLE; internal reload_reg=0, mode_reg=0.
  - Outputs are released on the first clk edge after rst falls.
- States: IDLE and RUN; busy is 1 exactly in RUN.
- Load (any state, en ignored that cycle), at the next edge:
  - q<=load_val, reload_reg<=load_val, mode_reg<=mode, tc<=0.
  - load_val != 0: state<=RUN.
  - load_val == 0: state<=IDLE, tc<=1 (zero-length count expires immediately).
- RUN, en=1, q>1: q<=q-1, tc<=0.
- RUN, en=1, q==1:
  - tc<=1 on that edge, so tc is high in the cycle where the expiry is visible.
  - mode_reg=0: q<=0, state<=IDLE.
  - mode_reg=1: q<=reload_reg, stay in RUN. The period is exactly reload_reg enabled cycles, with no dead cycle.
- RUN, en=0: q holds, tc<=0. en gating may stretch the count arbitrarily.
- IDLE, en=1, no load: no change. q never decrements below 0 and never wraps to all-ones.
- load and expiry on the same edge: load wins, tc<=0 (except load_val==0, which gives tc<=1 per the load rule).
- load_val = 2^WIDTH-1 is legal; the full count takes 2^WIDTH-1 enabled cycles.
- tc is never high on two consecutive cycles, except reload_reg==1 in auto-reload with en held high, where tc stays high every cycle.
- Latency: load to q valid is 1 cycle. The edge where q reaches its final value is the same edge that raises tc.

Decomposition:
- Shared package down_counter_pkg holds:
  - state encoding constants ST_IDLE=1'b0, ST_RUN=1'b1;
  - mode constants MODE_ONESHOT=1'b0, MODE_RELOAD=1'b1.
- One natural sub-module, down_counter_core: the WIDTH-bit register with load/decrement mux and the q==1 detect.
- The top level holds the FSM, reload_reg, mode_reg and the tc register.

Test Plan:
- Reset: rst=1 for 100 ns, then released mid-stream; rst reasserted at q=5 during a count -> q=0, tc=0, busy=0 immediately (asynchronous), with no edge required.
- One-shot: load_val=4'd5, mode=0, en=1 continuous -> q sequence 5,4,3,2,1,0; tc high only in the cycle q=0; busy falls in that same cycle; q stays 0 afterwards.
- Auto-reload: load_val=4'd3, mode=1, en=1 for 10 cycles -> q=3,2,1,3,2,1,3,...; tc pulses every 3rd cycle with q=3 visible; busy stays 1.
- Enable gating: load_val=4'd4, en toggled 1,0,0,1,1,1 -> q=4,3,3,3,2,1,0; tc on the final edge only.
- Load priority: load_val=4'd9 asserted on the same edge q goes 1->0 -> q=9, tc=0, busy=1. Separately, load_val=0 -> tc=1 for one cycle, busy=0.
- Boundary: load_val=4'hF, mode=0 -> exactly 15 enabled cycles to tc; no wrap to 4'hF afterwards while en stays high.
